// File: rtl/refill_arbiter_pkg.sv
// rtl/refill_arbiter_pkg.sv - shared cache refill constants, state encoding and AXI burst shape
package refill_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } refill_state_t;

  localparam logic [3:0] IC_ID_DEFAULT = 4'd0;
  localparam logic [3:0] DC_ID_DEFAULT = 4'd1;

  localparam int         LINE_WORDS = 8;
  localparam logic [2:0] LAST_BEAT  = 3'(LINE_WORDS - 1);

  localparam logic [7:0] AXI_LEN    = 8'd7;
  localparam logic [2:0] AXI_SIZE   = 3'b010;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin picker, one-hot grant
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_served,
  output logic [1:0] gnt
);

  // last_served: 0 means req[0] won last time, 1 means req[1]
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = last_served ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/refill_arbiter.sv
// rtl/refill_arbiter.sv - arbitrates icache/dcache line refills onto one AXI4 read burst at a time
module refill_arbiter
  import refill_arbiter_pkg::*;
#(
  parameter logic [3:0] IC_ID = IC_ID_DEFAULT,
  parameter logic [3:0] DC_ID = DC_ID_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ic_rd_req,
  input  logic [31:0]                  ic_addr,
  output logic                         ic_gnt,
  input  logic                         dc_rd_req,
  input  logic [31:0]                  dc_addr,
  output logic                         dc_gnt,
  output logic [LINE_WORDS-1:0][31:0]  line_data,
  output logic [3:0]                   arid,
  output logic [31:0]                  araddr,
  output logic [7:0]                   arlen,
  output logic [2:0]                   arsize,
  output logic [1:0]                   arburst,
  output logic                         arvalid,
  input  logic                         arready,
  input  logic [3:0]                   rid,
  input  logic [31:0]                  rdata,
  input  logic [1:0]                   rresp,
  input  logic                         rlast,
  input  logic                         rvalid,
  output logic                         rready,
  output logic                         protocol_err
);

  refill_state_t state_q, state_d;
  // winner_dc_q doubles as the last-served record for the round-robin picker
  logic          winner_dc_q;
  logic [31:0]   addr_q;
  logic [3:0]    id_q;
  logic [2:0]    count_q;
  logic          perr_q;
  logic [1:0]    pick;
  logic [31:0]   miss_addr;
  logic          any_req;
  logic          beat;
  logic          unused_sigs;

  rr_arb2 u_rr_arb2 (
    .req         ({dc_rd_req, ic_rd_req}),
    .last_served (winner_dc_q),
    .gnt         (pick)
  );

  assign any_req   = ic_rd_req || dc_rd_req;
  assign miss_addr = pick[1] ? dc_addr : ic_addr;
  assign beat      = rvalid && rready;

  assign arid         = id_q;
  assign araddr       = addr_q;
  assign arlen        = AXI_LEN;
  assign arsize       = AXI_SIZE;
  assign arburst      = BURST_INCR;
  assign protocol_err = perr_q;
  assign unused_sigs  = ^{rid, miss_addr[4:0], pick[0]};

  always_comb begin
    state_d = state_q;
    arvalid = 1'b0;
    rready  = 1'b0;
    ic_gnt  = 1'b0;
    dc_gnt  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // stray beats from an abandoned burst are drained here
        rready = 1'b1;
        if (any_req) state_d = ST_ADDR;
      end
      ST_ADDR: begin
        arvalid = 1'b1;
        if (arready) state_d = ST_DATA;
      end
      ST_DATA: begin
        rready = 1'b1;
        if (rvalid && count_q == LAST_BEAT) state_d = ST_DONE;
      end
      ST_DONE: begin
        ic_gnt  = !winner_dc_q;
        dc_gnt  = winner_dc_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      winner_dc_q <= 1'b1;
      addr_q      <= '0;
      id_q        <= '0;
      count_q     <= '0;
      perr_q      <= 1'b0;
      line_data   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && any_req) begin
        winner_dc_q <= pick[1];
        addr_q      <= {miss_addr[31:5], 5'b0};
        id_q        <= pick[1] ? DC_ID : IC_ID;
      end
      if (state_q == ST_ADDR && arready) begin
        count_q <= '0;
      end
      if (state_q == ST_DATA && beat) begin
        line_data[count_q] <= rdata;
        count_q            <= count_q + 3'd1;
        // completion counts beats; rlast is only checked for placement
        if ((rlast != (count_q == LAST_BEAT)) || (rresp != RESP_OKAY)) begin
          perr_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_refill_arbiter.sv
// tb/tb_refill_arbiter.sv - randomized self-checking bench for refill_arbiter
module tb_refill_arbiter;

  logic               clk = 1'b0;
  logic               rst;
  logic               ic_rd_req, dc_rd_req;
  logic [31:0]        ic_addr, dc_addr;
  logic               ic_gnt, dc_gnt;
  logic [7:0][31:0]   line_data;
  logic [3:0]         arid;
  logic [31:0]        araddr;
  logic [7:0]         arlen;
  logic [2:0]         arsize;
  logic [1:0]         arburst;
  logic               arvalid, arready;
  logic [3:0]         rid;
  logic [31:0]        rdata;
  logic [1:0]         rresp;
  logic               rlast, rvalid, rready;
  logic               protocol_err;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int gnt_cyc = 0;
  int ic_gnt_cnt = 0;
  int dc_gnt_cnt = 0;
  bit model_last_dc;
  bit model_perr;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (ic_gnt) ic_gnt_cnt++;
    if (dc_gnt) dc_gnt_cnt++;
  end

  refill_arbiter dut (
    .clk(clk), .rst(rst),
    .ic_rd_req(ic_rd_req), .ic_addr(ic_addr), .ic_gnt(ic_gnt),
    .dc_rd_req(dc_rd_req), .dc_addr(dc_addr), .dc_gnt(dc_gnt),
    .line_data(line_data),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready), .protocol_err(protocol_err)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    model_last_dc = 1'b1;
    model_perr    = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    ic_rd_req = 1'b0; dc_rd_req = 1'b0; ic_addr = '0; dc_addr = '0;
    arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rdata = '0; rid = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    reset_model();
  endtask

  task automatic check_idle_state(input string tag);
    check({tag, "_arvalid"}, arvalid, 1'b0);
    check({tag, "_gnts"}, {ic_gnt, dc_gnt}, 2'b00);
    check({tag, "_perr"}, protocol_err, 1'b0);
    check({tag, "_line"}, line_data, 256'd0);
    check({tag, "_rready"}, rready, 1'b1);
  endtask

  task automatic addr_phase(input int ar_delay, input logic [31:0] exp_addr,
                            input logic [3:0] exp_id, output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!arvalid && waited < 40);
    check("arvalid_seen", arvalid, 1'b1);
    check("araddr", araddr, exp_addr);
    check("arid", arid, exp_id);
    check("ar_shape", {arlen, arsize, arburst}, {8'd7, 3'd2, 2'd1});
    repeat (ar_delay) begin
      arready = 1'b0;
      @(negedge clk);
      check("araddr_stable", {arvalid, araddr}, {1'b1, exp_addr});
    end
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    check("arvalid_after_hs", arvalid, 1'b0);
  endtask

  task automatic send_beat(input logic [31:0] d, input bit last, input logic [1:0] resp, input bit gap);
    if (gap) begin
      rvalid = 1'b0;
      @(negedge clk);
    end
    check("rready", rready, 1'b1);
    rvalid = 1'b1; rdata = d; rlast = last; rresp = resp;
    @(negedge clk);
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
  endtask

  // mode: 0 drop winner's request at gnt, 1 keep all requests, 2 drop all
  task automatic serve_burst(input int ar_delay, input bit gap, input int bad_last_beat,
                             input int bad_resp_beat, input int mode, input bit fixed_data,
                             output int waited);
    logic [7:0][31:0] words;
    bit               win_dc;
    bit               last;
    logic [1:0]       resp;
    logic [31:0]      exp_addr;
    if (ic_rd_req && dc_rd_req) win_dc = !model_last_dc;
    else                        win_dc = dc_rd_req;
    model_last_dc = win_dc;
    exp_addr = (win_dc ? dc_addr : ic_addr) & 32'hFFFF_FFE0;
    for (int k = 0; k < 8; k++) words[k] = fixed_data ? 32'h100 + k : $urandom;
    addr_phase(ar_delay, exp_addr, win_dc ? 4'd1 : 4'd0, waited);
    for (int k = 0; k < 8; k++) begin
      last = (k == 7) ^ (k == bad_last_beat);
      resp = (k == bad_resp_beat) ? 2'b10 : 2'b00;
      if (last != (k == 7) || resp != 2'b00) model_perr = 1'b1;
      send_beat(words[k], last, resp, gap);
    end
    gnt_cyc = cyc;
    check("ic_gnt", ic_gnt, !win_dc);
    check("dc_gnt", dc_gnt, win_dc);
    check("line_data", line_data, words);
    check("protocol_err", protocol_err, model_perr);
    if (mode == 0) begin
      if (win_dc) dc_rd_req = 1'b0; else ic_rd_req = 1'b0;
    end else if (mode == 2) begin
      ic_rd_req = 1'b0; dc_rd_req = 1'b0;
    end
    @(negedge clk);
    check("gnt_pulse_end", {ic_gnt, dc_gnt}, 2'b00);
    check("line_hold", line_data, words);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    int t0;
    int ic0, dc0;
    @(negedge clk);

    // basic icache refill and minimum latency
    apply_reset();
    check_idle_state("reset");
    ic_addr = 32'hBFC0_0014; ic_rd_req = 1'b1; t0 = cyc;
    serve_burst(0, 0, -1, -1, 0, 1, waited);
    check("first_arvalid_latency", waited, 1);
    check("gnt_latency", gnt_cyc - t0, 10);
    check("line_word3", line_data[3], 32'h103);
    dc_addr = $urandom; dc_rd_req = 1'b1;
    serve_burst(0, 0, -1, -1, 0, 0, waited);
    check("back_to_back_latency", waited, 1);

    // simultaneous requests after reset
    apply_reset();
    ic0 = ic_gnt_cnt; dc0 = dc_gnt_cnt;
    ic_addr = $urandom; dc_addr = $urandom; ic_rd_req = 1'b1; dc_rd_req = 1'b1;
    serve_burst(0, 0, -1, -1, 0, 0, waited);
    serve_burst(0, 0, -1, -1, 0, 0, waited);
    repeat (3) @(negedge clk);
    check("tie_gnt_counts", {ic_gnt_cnt - ic0, dc_gnt_cnt - dc0}, {32'd1, 32'd1});

    // slow address ready and gapped data
    ic_addr = $urandom; ic_rd_req = 1'b1;
    serve_burst(3, 1, -1, -1, 0, 0, waited);

    // early rlast is flagged but the burst still completes
    dc_addr = $urandom; dc_rd_req = 1'b1;
    serve_burst(0, 0, 5, -1, 0, 0, waited);

    // reset mid-burst, strays drained in idle
    apply_reset();
    ic_addr = $urandom; ic_rd_req = 1'b1;
    addr_phase(0, ic_addr & 32'hFFFF_FFE0, 4'd0, waited);
    for (int k = 0; k < 3; k++) send_beat($urandom, 1'b0, 2'b00, 1'b0);
    rst = 1'b1; ic_rd_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    reset_model();
    ic0 = ic_gnt_cnt; dc0 = dc_gnt_cnt;
    for (int k = 3; k < 8; k++) begin
      send_beat($urandom, k == 7, 2'b00, 1'b0);
      check("drain_arvalid", arvalid, 1'b0);
    end
    repeat (2) @(negedge clk);
    check_idle_state("drain");
    check("drain_no_gnt", {ic_gnt_cnt - ic0, dc_gnt_cnt - dc0}, 64'd0);
    dc_addr = $urandom; dc_rd_req = 1'b1;
    serve_burst(1, 0, -1, -1, 0, 0, waited);

    // held dcache against a re-requesting icache
    apply_reset();
    ic0 = ic_gnt_cnt; dc0 = dc_gnt_cnt;
    ic_addr = $urandom; dc_addr = $urandom; ic_rd_req = 1'b1; dc_rd_req = 1'b1;
    serve_burst(0, 0, -1, -1, 1, 0, waited);
    serve_burst(0, 0, -1, -1, 1, 0, waited);
    serve_burst(0, 0, -1, -1, 2, 0, waited);
    repeat (3) @(negedge clk);
    check("alt_gnt_counts", {ic_gnt_cnt - ic0, dc_gnt_cnt - dc0}, {32'd2, 32'd1});

    // randomized traffic
    for (int it = 0; it < 10; it++) begin
      if (!ic_rd_req && $urandom_range(1, 0) == 1) begin ic_rd_req = 1'b1; ic_addr = $urandom; end
      if (!dc_rd_req && $urandom_range(1, 0) == 1) begin dc_rd_req = 1'b1; dc_addr = $urandom; end
      if (!ic_rd_req && !dc_rd_req) begin ic_rd_req = 1'b1; ic_addr = $urandom; end
      serve_burst($urandom_range(2, 0), $urandom_range(1, 0) == 1,
                  ($urandom_range(3, 0) == 0) ? int'($urandom_range(7, 0)) : -1,
                  ($urandom_range(3, 0) == 0) ? int'($urandom_range(7, 0)) : -1,
                  (it == 9) ? 2 : int'($urandom_range(1, 0)), 0, waited);
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
